// File: rtl/d7s_scan_ctrl.sv
// d7s_scan_ctrl: three-digit multiplexed seven-segment scan scheduler.
// Each digit gets DEAD blanking cycles followed by DIV lit cycles, in the
// order units -> tens -> hundreds. A new BCD value is accepted through a
// valid/ready handshake into a pending buffer. The value is swapped onto the
// display only on the last cycle of a frame, so the shown number never tears.
// Optional feature macro: D7S_LZB_EN (leading-zero blanking of tens/hundreds).
module d7s_scan_ctrl #(
    parameter int DIV  = 1000,
    parameter int DEAD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd_in,
    input  logic        load_valid,
    output logic        load_ready,
    output logic [2:0]  transistor,
    output logic [6:0]  d7sp,
    output logic        frame_done
);

    localparam int MAXC = (DIV > DEAD) ? DIV : DEAD;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);

    typedef enum logic {BLANK, ON} phase_t;

    phase_t          phase, phase_nx;
    logic [1:0]      digit, digit_nx;
    logic [CW-1:0]   cnt, cnt_nx;

    logic [11:0]     disp, pend, disp_nx;
    logic            pend_full;
    logic            frame_last, swap, accept;

    logic [2:0]      transistor_nx;
    logic [6:0]      d7sp_nx;
    logic            frame_done_nx;
    logic [3:0]      nib;
    logic            lz_blank;

    // Seven-segment decode {g,f,e,d,c,b,a}; non-BCD nibbles show a dash.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h40;
        endcase
    endfunction

    // Last cycle of the hundreds ON phase closes the frame.
    assign frame_last = (phase == ON) && (digit == 2'd2) && (cnt == DIV_LAST);
    // Ready is low whenever a swap happens, so swap and accept are exclusive.
    assign swap       = frame_last && pend_full;
    assign accept     = load_valid && !pend_full;
    assign load_ready = !pend_full;
    assign disp_nx    = swap ? pend : disp;

    // Phase FSM state register.
    // NOTE: every clocked process uses non-blocking assignments so all state updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= BLANK;
            digit <= 2'd0;
            cnt   <= '0;
        end else begin
            phase <= phase_nx;
            digit <= digit_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic: BLANK for DEAD cycles, ON for DIV cycles, then next digit.
    // NOTE: defaults at the top of a combinational block keep every path assigned, so no latch is inferred.
    always_comb begin
        phase_nx = phase;
        digit_nx = digit;
        cnt_nx   = cnt + CW'(1);
        case (phase)
            BLANK: begin
                if (cnt == DEAD_LAST) begin
                    phase_nx = ON;
                    cnt_nx   = '0;
                end
            end
            ON: begin
                if (cnt == DIV_LAST) begin
                    phase_nx = BLANK;
                    cnt_nx   = '0;
                    digit_nx = (digit == 2'd2) ? 2'd0 : digit + 2'd1;
                end
            end
            default: begin
                phase_nx = BLANK;
                cnt_nx   = '0;
                digit_nx = 2'd0;
            end
        endcase
    end

    // Double buffer: accept into pend, move pend to disp at the frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp      <= 12'h000;
            pend      <= 12'h000;
            pend_full <= 1'b0;
        end else begin
            disp <= disp_nx;
            if (swap) begin
                pend_full <= 1'b0;
            end else if (accept) begin
                pend      <= bcd_in;
                pend_full <= 1'b1;
            end
        end
    end

    // Output decode from the next state, so the registered outputs line up with the phase.
    always_comb begin
        transistor_nx = 3'b000;
        d7sp_nx       = 7'h00;
        frame_done_nx = 1'b0;
        lz_blank      = 1'b0;
        case (digit_nx)
            2'd1:    nib = disp_nx[7:4];
            2'd2:    nib = disp_nx[11:8];
            default: nib = disp_nx[3:0];
        endcase
`ifdef D7S_LZB_EN
        if (digit_nx == 2'd2)
            lz_blank = (disp_nx[11:8] == 4'd0);
        else if (digit_nx == 2'd1)
            lz_blank = (disp_nx[11:8] == 4'd0) && (disp_nx[7:4] == 4'd0);
`endif
        if (phase_nx == ON) begin
            transistor_nx = 3'b001 << digit_nx;
            d7sp_nx       = lz_blank ? 7'h00 : seg7(nib);
            frame_done_nx = (digit_nx == 2'd2) && (cnt_nx == DIV_LAST);
        end
    end

    // Output registers: pins are driven only from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            transistor <= 3'b000;
            d7sp       <= 7'h00;
            frame_done <= 1'b0;
        end else begin
            transistor <= transistor_nx;
            d7sp       <= d7sp_nx;
            frame_done <= frame_done_nx;
        end
    end

endmodule

// File: tb/tb_d7s_scan_ctrl.sv
// Directed testbench for d7s_scan_ctrl with DIV=4, DEAD=2 (slot 6, frame 18).
// Compile with D7S_LZB_EN defined to exercise leading-zero blanking.
module tb_d7s_scan_ctrl;

    localparam int DIV   = 4;
    localparam int DEAD  = 2;
    localparam int SLOT  = DIV + DEAD;
    localparam int FRAME = 3 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] bcd_in = 12'h000;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [2:0]  transistor;
    logic [6:0]  d7sp;
    logic        frame_done;

    d7s_scan_ctrl #(.DIV(DIV), .DEAD(DEAD)) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .transistor (transistor),
        .d7sp       (d7sp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          t        = 0;
    logic [11:0] mdisp    = 12'h000;
    logic [11:0] mpend    = 12'h000;
    logic        mfull    = 1'b0;
    logic [2:0]  prev_tr  = 3'b000;
    int          zero_run = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d: got=%0h expected=%0h", tag, t, got, exp);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'd0: seg = 7'h3F;  4'd1: seg = 7'h06;  4'd2: seg = 7'h5B;
            4'd3: seg = 7'h4F;  4'd4: seg = 7'h66;  4'd5: seg = 7'h6D;
            4'd6: seg = 7'h7D;  4'd7: seg = 7'h07;  4'd8: seg = 7'h7F;
            4'd9: seg = 7'h6F;  default: seg = 7'h40;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [11:0] v, input int dg);
        logic [11:0] sh;
        sh = v >> (4 * dg);
`ifdef D7S_LZB_EN
        if (dg == 2 && v[11:8] == 4'd0) return 7'h00;
        if (dg == 1 && v[11:8] == 4'd0 && v[7:4] == 4'd0) return 7'h00;
`endif
        return seg(sh[3:0]);
    endfunction

    // Compare every output against the frame-position model.
    task automatic check_model();
        int slot, dg, w;
        logic on;
        slot = t % FRAME;
        dg   = slot / SLOT;
        w    = slot % SLOT;
        on   = (w >= DEAD);
        check("transistor", transistor, on ? (3'b001 << dg) : 3'b000);
        check("d7sp", d7sp, on ? exp_seg(mdisp, dg) : 7'h00);
        check("frame_done", frame_done, (slot == FRAME - 1));
        check("load_ready", load_ready, !mfull);
        check("onehot0", $onehot0(transistor), 1'b1);
        if (transistor != 3'b000 && prev_tr == 3'b000)
            check("dead_gap", (zero_run >= DEAD), 1'b1);
        if (transistor != 3'b000 && prev_tr != 3'b000)
            check("no_direct_switch", transistor, prev_tr);
        zero_run = (transistor == 3'b000) ? zero_run + 1 : 0;
        prev_tr  = transistor;
    endtask

    task automatic tick();
        @(posedge clk);
        if ((t % FRAME) == FRAME - 1 && mfull) begin
            mdisp = mpend;
            mfull = 1'b0;
        end else if (load_valid && !mfull) begin
            mpend = bcd_in;
            mfull = 1'b1;
        end
        t++;
        #1;
        check_model();
    endtask

    task automatic load(input logic [11:0] v);
        int n;
        n          = 0;
        bcd_in     = v;
        load_valid = 1'b1;
        while (mfull && n < 3 * FRAME) begin
            tick();
            n++;
        end
        check("load_wait_bound", (n < 3 * FRAME), 1'b1);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic wait_swap();
        int n;
        n = 0;
        while (mfull && n < 3 * FRAME) begin
            tick();
            n++;
        end
        check("swap_wait_bound", (n < 3 * FRAME), 1'b1);
    endtask

    task automatic wait_on(input int dg);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((t % FRAME) != dg * SLOT + DEAD && n <= FRAME);
        check("wait_on_bound", (n <= FRAME), 1'b1);
    endtask

    task automatic show_check(input logic [11:0] v, input logic [6:0] e0,
                              input logic [6:0] e1, input logic [6:0] e2);
        load(v);
        wait_swap();
        wait_on(0);
        check("show_units", d7sp, e0);
        check("show_units_tr", transistor, 3'b001);
        wait_on(1);
        check("show_tens", d7sp, e1);
        check("show_tens_tr", transistor, 3'b010);
        wait_on(2);
        check("show_hund", d7sp, e2);
        check("show_hund_tr", transistor, 3'b100);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        t        = 0;
        mdisp    = 12'h000;
        mfull    = 1'b0;
        prev_tr  = 3'b000;
        zero_run = 0;
        check_model();
    endtask

    initial begin
        int t0, n;
        bit was_full;

        // Power-on reset and first digit timing.
        repeat (3) @(posedge clk);
        release_reset();
        check("rst_tr", transistor, 3'b000);
        check("rst_seg", d7sp, 7'h00);
        check("rst_ready", load_ready, 1'b1);
        tick();
        check("blank1_tr", transistor, 3'b000);
        tick();
        check("first_on_tr", transistor, 3'b001);
        check("first_on_seg", d7sp, 7'h3F);

        // Asynchronous reset mid-ON with a pending value held.
        bcd_in     = 12'h999;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        check("pend_full_ready", load_ready, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("async_rst_tr", transistor, 3'b000);
        check("async_rst_seg", d7sp, 7'h00);
        check("async_rst_fd", frame_done, 1'b0);
        check("async_rst_ready", load_ready, 1'b1);
        repeat (2) @(posedge clk);
        release_reset();
        tick();
        tick();
        check("post_rst_on_tr", transistor, 3'b001);
        check("post_rst_on_seg", d7sp, 7'h3F);
        wait_on(0);
        check("pend_discarded", d7sp, 7'h3F);

        // Load 123 and verify frame_done period.
        show_check(12'h123, 7'h4F, 7'h5B, 7'h06);
        n = 0;
        while (frame_done !== 1'b1 && n < 2 * FRAME) begin tick(); n++; end
        t0 = t;
        n  = 0;
        do begin tick(); n++; end while (frame_done !== 1'b1 && n < 2 * FRAME);
        check("frame_period", t - t0, FRAME);

        // Back-to-back loads: the second stalls until the swap.
        load(12'h456);
        check("b2b_stall_ready", load_ready, 1'b0);
        load(12'h789);
        wait_on(0);
        check("b2b_first_units", d7sp, 7'h7D);
        wait_on(1);
        check("b2b_first_tens", d7sp, 7'h6D);
        wait_on(2);
        check("b2b_first_hund", d7sp, 7'h66);
        wait_swap();
        wait_on(0);
        check("b2b_second_units", d7sp, 7'h6F);
        wait_on(1);
        check("b2b_second_tens", d7sp, 7'h7F);
        wait_on(2);
        check("b2b_second_hund", d7sp, 7'h07);

`ifdef D7S_LZB_EN
        show_check(12'h0A5, 7'h6D, 7'h40, 7'h00);
        show_check(12'h007, 7'h07, 7'h00, 7'h00);
        show_check(12'h000, 7'h3F, 7'h00, 7'h00);
`else
        show_check(12'h0A5, 7'h6D, 7'h40, 7'h3F);
        show_check(12'h007, 7'h07, 7'h3F, 7'h3F);
        show_check(12'h000, 7'h3F, 7'h3F, 7'h3F);
`endif

        // 100-frame scan with sporadic random loads.
        for (int i = 0; i < 100 * FRAME; i++) begin
            if (!load_valid && $urandom_range(0, 9) == 0) begin
                bcd_in     = 12'($urandom);
                load_valid = 1'b1;
            end
            was_full = mfull;
            tick();
            if (load_valid && !was_full) load_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
